// File: rtl/nand2_delay_meter_if.sv
// Result handshake bundle for nand2_delay_meter: the meter drives the result and
// meas_valid, and the consumer drives meas_ready.
interface nand2_delay_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] delay;
  logic             dir;
  logic             timeout;

  modport master (output meas_valid, delay, dir, timeout, input meas_ready);
  modport slave  (input meas_valid, delay, dir, timeout, output meas_ready);
endinterface

// File: rtl/nand2_delay_meter.sv
// Measures NAND2 output propagation delay in clk cycles from trig to a threshold crossing of Y.
// Optional macro DELAY_TIMEOUT_EN: end MEASURE after TIMEOUT cycles with timeout=1.
module nand2_delay_meter #(
  parameter int  CNT_W   = 16,
  parameter real TH_FRAC = 0.5,
  parameter int  TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  real                 Y,
  input  real                 VDD,
  input  logic                trig,
  input  logic                trig_dir,
  nand2_delay_meter_if.master res,
  output logic                busy,
  output logic                overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

`ifdef DELAY_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef struct packed {
    logic [CNT_W-1:0] delay;
    logic             dir;
    logic             timeout;
  } result_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  result_t          rslt;
  logic             valid;
  logic             y_hi;
  logic             cross_idle;
  logic             cross_meas;
  logic             to_hit;

  assign y_hi       = (Y > TH_FRAC * VDD);
  assign cross_idle = (y_hi == trig_dir);
  // Once measuring, the direction captured at trig decides the crossing.
  assign cross_meas = (y_hi == rslt.dir);
  assign cnt_nxt    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign to_hit     = TO_EN && (cnt_nxt == TO_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rslt    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            rslt.dir     <= trig_dir;
            rslt.timeout <= 1'b0;
            busy         <= 1'b1;
            if (cross_idle) begin
              rslt.delay <= '0;
              valid      <= 1'b1;
              state      <= HOLD;
            end else begin
              cnt   <= '0;
              state <= MEASURE;
            end
          end
        end
        MEASURE: begin
          if (trig) overrun <= 1'b1;
          // A crossing wins over a timeout landing on the same edge.
          if (cross_meas) begin
            rslt.delay <= cnt_nxt;
            valid      <= 1'b1;
            state      <= HOLD;
          end else if (to_hit) begin
            rslt.delay   <= TO_VAL;
            rslt.timeout <= 1'b1;
            valid        <= 1'b1;
            state        <= HOLD;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        HOLD: begin
          if (trig) overrun <= 1'b1;
          if (res.meas_ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign res.meas_valid = valid;
  assign res.delay      = rslt.delay;
  assign res.dir        = rslt.dir;
  assign res.timeout    = TO_EN & rslt.timeout;

endmodule

// File: tb/tb_nand2_delay_meter.sv
// Directed bench for nand2_delay_meter: CNT_W=4 and TIMEOUT=8 so that saturation and
// timeout are reachable in a few cycles.
module tb_nand2_delay_meter;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  real  y   = 1.0;
  real  vdd = 1.0;
  logic trig = 1'b0;
  logic trig_dir = 1'b0;
  logic busy, overrun;
  int   total = 0;
  int   bad = 0;

  nand2_delay_meter_if #(.CNT_W(CW)) bus ();

  nand2_delay_meter #(.CNT_W(CW), .TH_FRAC(0.5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .Y(y), .VDD(vdd), .trig(trig), .trig_dir(trig_dir),
    .res(bus), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; trig = 1'b0; bus.meas_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.meas_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({bus.meas_valid, busy, overrun, bus.timeout, bus.dir, bus.delay} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {bus.meas_valid, busy, overrun, bus.timeout, bus.dir, bus.delay});
    end
    rst = 1'b0;
  endtask

  task automatic test_fall_and_hold();
    do_reset();
    vdd = 1.0; y = 1.0; trig_dir = 1'b0; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    total++;
    if ({busy, bus.meas_valid} !== 2'b10) begin
      bad++; $display("FAIL fall_measuring: got busy,valid=%b want 10", {busy, bus.meas_valid});
    end
    @(negedge clk);
    @(negedge clk); y = 0.2;
    @(negedge clk);
    total++;
    if ({bus.meas_valid, bus.delay, bus.dir, bus.timeout} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL fall_result: got valid=%0d delay=%0d dir=%0d to=%0d want 1 3 0 0",
                      bus.meas_valid, bus.delay, bus.dir, bus.timeout);
    end
    for (int i = 0; i < 5; i++) begin
      trig = (i == 2);
      @(negedge clk);
      total++;
      if ({bus.meas_valid, bus.delay, bus.dir, bus.timeout, busy} !== {1'b1, 4'd3, 1'b0, 1'b0, 1'b1}) begin
        bad++; $display("FAIL hold_stable[%0d]: got valid=%0d delay=%0d dir=%0d to=%0d want 1 3 0 0", i,
                        bus.meas_valid, bus.delay, bus.dir, bus.timeout);
      end
    end
    trig = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL hold_trig_overrun: got %0d want 1", overrun);
    end
    bus.meas_ready = 1'b1;
    @(negedge clk); bus.meas_ready = 1'b0;
    total++;
    if ({bus.meas_valid, busy, overrun} !== 3'b001) begin
      bad++; $display("FAIL hold_accept: got valid,busy,overrun=%b want 001", {bus.meas_valid, busy, overrun});
    end
  endtask

  task automatic test_immediate();
    do_reset();
    vdd = 1.0; y = 1.0; trig_dir = 1'b1; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    total++;
    if ({bus.meas_valid, bus.delay, bus.dir, busy, overrun} !== {1'b1, 4'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL immediate_result: got valid=%0d delay=%0d dir=%0d busy=%0d ovr=%0d want 1 0 1 1 0",
                      bus.meas_valid, bus.delay, bus.dir, busy, overrun);
    end
    bus.meas_ready = 1'b1; trig = 1'b1;
    @(negedge clk); bus.meas_ready = 1'b0; trig = 1'b0;
    total++;
    if ({bus.meas_valid, busy, overrun} !== 3'b001) begin
      bad++; $display("FAIL handshake_trig: got valid,busy,overrun=%b want 001", {bus.meas_valid, busy, overrun});
    end
    @(negedge clk);
    total++;
    if ({bus.meas_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL handshake_trig_ignored: got valid,busy=%b want 00", {bus.meas_valid, busy});
    end
  endtask

  task automatic test_rise_threshold();
    // VDD=2.0 puts the threshold at 1.0, so Y=0.8 is still low.
    do_reset();
    vdd = 2.0; y = 0.8; trig_dir = 1'b1; trig = 1'b1; bus.meas_ready = 1'b1;
    @(negedge clk); trig = 1'b0;
    total++;
    if ({busy, bus.meas_valid} !== 2'b10) begin
      bad++; $display("FAIL rise_measuring: got busy,valid=%b want 10", {busy, bus.meas_valid});
    end
    @(negedge clk); y = 1.2;
    @(negedge clk);
    total++;
    if ({bus.meas_valid, bus.delay, bus.dir} !== {1'b1, 4'd2, 1'b1}) begin
      bad++; $display("FAIL rise_result: got valid=%0d delay=%0d dir=%0d want 1 2 1",
                      bus.meas_valid, bus.delay, bus.dir);
    end
    @(negedge clk); bus.meas_ready = 1'b0;
    total++;
    if ({bus.meas_valid, busy, overrun} !== 3'b000) begin
      bad++; $display("FAIL rise_accept: got valid,busy,overrun=%b want 000", {bus.meas_valid, busy, overrun});
    end
  endtask

  task automatic test_rst_mid_measure();
    do_reset();
    vdd = 1.0; y = 0.0; trig_dir = 1'b1; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (dut.cnt !== 4'd4) begin
      bad++; $display("FAIL mid_count: got %0d want 4", dut.cnt);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++;
    if ({bus.meas_valid, busy, overrun, bus.timeout, bus.dir, bus.delay} !== 9'd0) begin
      bad++; $display("FAIL mid_reset: got %b want 0", {bus.meas_valid, busy, overrun, bus.timeout, bus.dir, bus.delay});
    end
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    @(negedge clk); y = 1.0;
    @(negedge clk);
    total++;
    if ({bus.meas_valid, bus.delay, bus.dir} !== {1'b1, 4'd2, 1'b1}) begin
      bad++; $display("FAIL after_reset_result: got valid=%0d delay=%0d dir=%0d want 1 2 1",
                      bus.meas_valid, bus.delay, bus.dir);
    end
  endtask

`ifdef DELAY_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    logic seen;
    do_reset();
    vdd = 1.0; y = 1.0; trig_dir = 1'b0; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      seen = bus.meas_valid;
    end
    total++;
    if (!seen || n != 8) begin
      bad++; $display("FAIL timeout_latency: got seen=%0d cycles=%0d want 1 8", seen, n);
    end
    total++;
    if ({bus.delay, bus.timeout} !== {4'd8, 1'b1}) begin
      bad++; $display("FAIL timeout_result: got delay=%0d to=%0d want 8 1", bus.delay, bus.timeout);
    end
    bus.meas_ready = 1'b1;
    @(negedge clk); bus.meas_ready = 1'b0;
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (7) @(negedge clk);
    y = 0.2;
    @(negedge clk);
    total++;
    if ({bus.meas_valid, bus.delay, bus.timeout} !== {1'b1, 4'd8, 1'b0}) begin
      bad++; $display("FAIL cross_beats_timeout: got valid=%0d delay=%0d to=%0d want 1 8 0",
                      bus.meas_valid, bus.delay, bus.timeout);
    end
  endtask
`else
  task automatic test_saturate();
    logic seen;
    do_reset();
    vdd = 1.0; y = 1.0; trig_dir = 1'b0; trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.meas_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL no_result_without_cross: got valid seen=%0d want 0", seen);
    end
    total++;
    if (dut.cnt !== 4'd15) begin
      bad++; $display("FAIL counter_saturates: got %0d want 15", dut.cnt);
    end
    y = 0.2;
    @(negedge clk);
    total++;
    if ({bus.meas_valid, bus.delay, bus.timeout} !== {1'b1, 4'd15, 1'b0}) begin
      bad++; $display("FAIL saturated_result: got valid=%0d delay=%0d to=%0d want 1 15 0",
                      bus.meas_valid, bus.delay, bus.timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fall_and_hold();
    test_immediate();
    test_rise_threshold();
    test_rst_mid_measure();
`ifdef DELAY_TIMEOUT_EN
    test_timeout();
`else
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
